// File: rtl/montgomery_mult_ctrl_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier controller:
// default widths, FSM state encoding and adder operand selection.
package montgomery_mult_ctrl_pkg;

  localparam int MM_N_DEFAULT = 1024;
  // Adder operands carry three headroom bits above N; C itself needs two
  // because C+B+M stays below 4M.
  localparam int MM_AW_EXTRA  = 3;
  localparam int MM_C_EXTRA   = 2;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CHK_A  = 4'd1,
    ST_WAIT_B = 4'd2,
    ST_CHK_P  = 4'd3,
    ST_WAIT_M = 4'd4,
    ST_SHIFT  = 4'd5,
    ST_SUB    = 4'd6,
    ST_WAIT_S = 4'd7,
    ST_DONE   = 4'd8
  } mm_state_e;

  typedef enum logic {
    OPSEL_B = 1'b0,
    OPSEL_M = 1'b1
  } mm_opsel_e;

endpackage

// File: rtl/montgomery_mult_ctrl_operand_mux.sv
// Selects the adder's b operand between multiplicand B and modulus M,
// zero-extended to the adder operand width.
module montgomery_mult_ctrl_operand_mux
  import montgomery_mult_ctrl_pkg::*;
#(
  parameter int N  = MM_N_DEFAULT,
  parameter int AW = N + MM_AW_EXTRA
) (
  input  mm_opsel_e     sel,
  input  logic [N-1:0]  op_b,
  input  logic [N-1:0]  op_m,
  output logic [AW-1:0] operand
);

  genvar gi;
  generate
    for (gi = 0; gi < AW; gi++) begin : g_bit
      if (gi < N) begin : g_data
        assign operand[gi] = (sel == OPSEL_M) ? op_m[gi] : op_b[gi];
      end else begin : g_pad
        assign operand[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/montgomery_mult_ctrl.sv
// Radix-2 Montgomery multiplier controller: R = A*B*2^-N mod M, issuing every
// add and subtract to an external shared multi-precision adder.
module montgomery_mult_ctrl
  import montgomery_mult_ctrl_pkg::*;
#(
  parameter int N     = MM_N_DEFAULT,
  parameter int AW    = N + MM_AW_EXTRA,
  parameter int CNT_W = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          add_start,
  output logic          add_sub,
  output logic [AW-1:0] add_a,
  output logic [AW-1:0] add_b,
  input  logic [AW:0]   add_result,
  input  logic          add_done
);

  localparam int CW = N + MM_C_EXTRA;

  mm_state_e         state_reg;
  logic [N-1:0]      a_reg;
  logic [N-1:0]      b_reg;
  logic [N-1:0]      m_reg;
  logic [CW-1:0]     c_reg;
  logic [CNT_W-1:0]  i_reg;

  mm_opsel_e         opsel;
  logic [AW-1:0]     operand_b;
  logic [AW-1:0]     c_ext;
  logic              last_iter;
  logic              borrow;
  logic              unused_add_hi;

  // Only the A-bit step adds B; the parity correction and final subtract use M.
  assign opsel     = (state_reg == ST_CHK_A) ? OPSEL_B : OPSEL_M;
  assign c_ext     = {{(AW-CW){1'b0}}, c_reg};
  assign last_iter = (i_reg == CNT_W'(N - 1));
  assign borrow    = add_result[AW];

  assign unused_add_hi = ^add_result[AW-1:CW];

  montgomery_mult_ctrl_operand_mux #(
    .N  (N),
    .AW (AW)
  ) u_operand_mux (
    .sel     (opsel),
    .op_b    (b_reg),
    .op_m    (m_reg),
    .operand (operand_b)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      m_reg     <= '0;
      c_reg     <= '0;
      i_reg     <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      add_start <= 1'b0;
      add_sub   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      add_start <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            m_reg     <= in_m;
            c_reg     <= '0;
            i_reg     <= '0;
            busy      <= 1'b1;
            state_reg <= ST_CHK_A;
          end
        end
        ST_CHK_A: begin
          if (a_reg[i_reg]) begin
            add_a     <= c_ext;
            add_b     <= operand_b;
            add_sub   <= 1'b0;
            add_start <= 1'b1;
            state_reg <= ST_WAIT_B;
          end else begin
            state_reg <= ST_CHK_P;
          end
        end
        ST_WAIT_B: begin
          // C+B can reach 3M, so the full CW-bit sum is kept.
          if (add_done) begin
            c_reg     <= add_result[CW-1:0];
            state_reg <= ST_CHK_P;
          end
        end
        ST_CHK_P: begin
          if (c_reg[0]) begin
            add_a     <= c_ext;
            add_b     <= operand_b;
            add_sub   <= 1'b0;
            add_start <= 1'b1;
            state_reg <= ST_WAIT_M;
          end else begin
            state_reg <= ST_SHIFT;
          end
        end
        ST_WAIT_M: begin
          if (add_done) begin
            c_reg     <= add_result[CW-1:0];
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          c_reg <= c_reg >> 1;
          if (last_iter) begin
            state_reg <= ST_SUB;
          end else begin
            i_reg     <= i_reg + 1'b1;
            state_reg <= ST_CHK_A;
          end
        end
        ST_SUB: begin
          add_a     <= c_ext;
          add_b     <= operand_b;
          add_sub   <= 1'b1;
          add_start <= 1'b1;
          state_reg <= ST_WAIT_S;
        end
        ST_WAIT_S: begin
          // A borrow means C < M already, so C is the reduced result.
          if (add_done) begin
            result    <= borrow ? c_reg[N-1:0] : add_result[N-1:0];
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_ctrl.sv
// Bench for montgomery_mult_ctrl: an 8-bit and a 1024-bit instance, each driving
// a behavioural adder with programmable latency, checked against a REDC model.
module tb_montgomery_mult_ctrl;

  localparam int N8  = 8;
  localparam int AW8 = N8 + 3;
  localparam int NW  = 1024;
  localparam int AWW = NW + 3;

  typedef logic [2*NW+1:0] wide_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [3:0] lat;
    logic [7:0] exp;
  } vec8_t;

  localparam int NTBL = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cov_take = 0;
  int cov_skip = 0;

  // ---------------- 8-bit instance ----------------
  logic           resetn8 = 1'b0;
  logic           start8  = 1'b0;
  logic [N8-1:0]  in_a8 = '0, in_b8 = '0, in_m8 = '0;
  logic [N8-1:0]  result8;
  logic           done8, busy8, add_start8, add_sub8;
  logic [AW8-1:0] add_a8, add_b8;
  logic [AW8:0]   add_result8 = '0;
  logic           add_done8 = 1'b0;

  montgomery_mult_ctrl #(.N(N8)) u_dut8 (
    .clk        (clk),
    .resetn     (resetn8),
    .start      (start8),
    .in_a       (in_a8),
    .in_b       (in_b8),
    .in_m       (in_m8),
    .result     (result8),
    .done       (done8),
    .busy       (busy8),
    .add_start  (add_start8),
    .add_sub    (add_sub8),
    .add_a      (add_a8),
    .add_b      (add_b8),
    .add_result (add_result8),
    .add_done   (add_done8)
  );

  // ---------------- 1024-bit instance ----------------
  logic           resetnw = 1'b0;
  logic           startw  = 1'b0;
  logic [NW-1:0]  in_aw = '0, in_bw = '0, in_mw = '0;
  logic [NW-1:0]  resultw;
  logic           donew, busyw, add_startw, add_subw;
  logic [AWW-1:0] add_aw, add_bw;
  logic [AWW:0]   add_resultw = '0;
  logic           add_donew = 1'b0;

  montgomery_mult_ctrl #(.N(NW)) u_dutw (
    .clk        (clk),
    .resetn     (resetnw),
    .start      (startw),
    .in_a       (in_aw),
    .in_b       (in_bw),
    .in_m       (in_mw),
    .result     (resultw),
    .done       (donew),
    .busy       (busyw),
    .add_start  (add_startw),
    .add_sub    (add_subw),
    .add_a      (add_aw),
    .add_b      (add_bw),
    .add_result (add_resultw),
    .add_done   (add_donew)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Word-level REDC reference: t = (ab + ((-ab * m^-1) mod 2^n) * m) / 2^n.
  function automatic wide_t redc_ref(input wide_t a, input wide_t b, input wide_t m, input int n);
    wide_t mask, inv, k, t, ab;
    mask = (wide_t'(1) << n) - wide_t'(1);
    inv  = m;
    for (int j = 0; j < 12; j++)
      inv = (inv * (wide_t'(2) - ((m * inv) & mask))) & mask;
    ab = a * b;
    k  = ((wide_t'(0) - ab) * inv) & mask;
    t  = (ab + k * m) >> n;
    if (t >= m) t = t - m;
    return t;
  endfunction

  function automatic logic [NW-1:0] rand_wide();
    logic [NW-1:0] v;
    for (int j = 0; j < NW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- behavioural adders (negedge-driven) ----------------
  int lat8 = 1, cnt8 = 0, n_add8 = 0, n_sub8 = 0;
  bit pend8 = 0, stale8 = 0, sub8 = 0;
  logic [AW8-1:0] opa8 = '0, opb8 = '0;

  always @(negedge clk) begin
    add_done8 = 1'b0;
    if (!resetn8) stale8 = 1'b1;
    if (pend8) begin
      cnt8--;
      if (cnt8 <= 0) begin
        pend8 = 1'b0;
        add_done8 = 1'b1;
        add_result8 = sub8 ? ({1'b0, opa8} - {1'b0, opb8}) : ({1'b0, opa8} + {1'b0, opb8});
        if (!stale8) begin
          check("operands_held8", {add_a8, add_b8, add_sub8}, {opa8, opb8, sub8});
          if (sub8) begin
            if (add_result8[AW8]) cov_skip++;
            else cov_take++;
          end
        end
      end
    end
    if (add_start8) begin
      check("add_overlap8", 64'(pend8), 64'd0);
      pend8 = 1'b1; cnt8 = lat8; stale8 = 1'b0;
      opa8 = add_a8; opb8 = add_b8; sub8 = add_sub8;
      n_add8++;
      if (add_sub8) n_sub8++;
    end
  end

  int latw = 1, cntw = 0;
  bit pendw = 0, subw = 0;
  logic [AWW-1:0] opaw = '0, opbw = '0;

  always @(negedge clk) begin
    add_donew = 1'b0;
    if (pendw) begin
      cntw--;
      if (cntw <= 0) begin
        pendw = 1'b0;
        add_donew = 1'b1;
        add_resultw = subw ? ({1'b0, opaw} - {1'b0, opbw}) : ({1'b0, opaw} + {1'b0, opbw});
        check("operands_heldw", 64'(add_aw === opaw && add_bw === opbw && add_subw === subw), 64'd1);
        if (subw) begin
          if (add_resultw[AWW]) cov_skip++;
          else cov_take++;
        end
      end
    end
    if (add_startw) begin
      check("add_overlapw", 64'(pendw), 64'd0);
      pendw = 1'b1; cntw = latw;
      opaw = add_aw; opbw = add_bw; subw = add_subw;
    end
  end

  // ---------------- scoreboards ----------------
  logic [7:0]    q8[$];
  logic [NW-1:0] qw[$];
  int done_cnt8 = 0, done_cntw = 0;
  bit prev_done8 = 0, prev_donew = 0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (done8) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done8 actual=done result=%0d required=no done", result8);
      end else begin
        e = q8.pop_front();
        $display("op8 a=%0d b=%0d m=%0d result=%0d expected=%0d", in_a8, in_b8, in_m8, result8, e);
        check("result8", 64'(result8), 64'(e));
      end
      check("done_pulse8", 64'(prev_done8), 64'd0);
      done_cnt8++;
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    logic [NW-1:0] e;
    if (donew) begin
      if (qw.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_donew actual=done required=no done");
      end else begin
        e = qw.pop_front();
        $display("opw result[63:0]=%h expected[63:0]=%h", resultw[63:0], e[63:0]);
        n_checks++;
        if (resultw !== e) begin
          n_fail++;
          $display("FAIL resultw actual[63:0]=%h required[63:0]=%h", resultw[63:0], e[63:0]);
        end
      end
      check("done_pulsew", 64'(prev_donew), 64'd0);
      done_cntw++;
    end
    prev_donew = donew;
  end

  // ---------------- stimulus tasks ----------------
  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                           input logic [7:0] e, input bit push);
    @(negedge clk);
    in_a8 = a; in_b8 = b; in_m8 = m; start8 = 1'b1;
    if (push) q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input int base);
    int cyc = 0;
    while (done_cnt8 == base && cyc < 5000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (done_cnt8 == base) begin
      n_fail++;
      $display("FAIL timeout8 actual=no done after %0d cycles required=done", cyc);
      q8.delete();
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                      input int lat, input logic [7:0] e);
    int base;
    lat8 = lat;
    base = done_cnt8;
    start8_op(a, b, m, e, 1'b1);
    wait_done8(base);
    @(negedge clk);
    check("idle_after8", 64'(busy8), 64'd0);
  endtask

  task automatic runw(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic [NW-1:0] m);
    int base, cyc;
    wide_t r;
    r = redc_ref(wide_t'(a), wide_t'(b), wide_t'(m), NW);
    base = done_cntw;
    @(negedge clk);
    in_aw = a; in_bw = b; in_mw = m; startw = 1'b1;
    qw.push_back(r[NW-1:0]);
    @(negedge clk);
    startw = 1'b0;
    cyc = 0;
    while (done_cntw == base && cyc < 20000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (done_cntw == base) begin
      n_fail++;
      $display("FAIL timeoutw actual=no done after %0d cycles required=done", cyc);
      qw.delete();
    end
    @(negedge clk);
    check("idle_afterw", 64'(busyw), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  vec8_t tbl [NTBL];

  initial begin
    logic [7:0]    ra, rb, rm;
    logic [NW-1:0] wa, wb, wm;
    wide_t         r;
    int            base;

    tbl[0] = '{8'd5,   8'd7,   8'd13,  4'd1, 8'd1};
    tbl[1] = '{8'd1,   8'd1,   8'd13,  4'd3, 8'd3};
    tbl[2] = '{8'd0,   8'd12,  8'd13,  4'd2, 8'd0};
    tbl[3] = '{8'd12,  8'd12,  8'd13,  4'd5, 8'd3};
    tbl[4] = '{8'd12,  8'd1,   8'd13,  4'd4, 8'd10};
    tbl[5] = '{8'd254, 8'd254, 8'd255, 4'd2, 8'd1};
    tbl[6] = '{8'd200, 8'd100, 8'd255, 4'd1, 8'd110};
    tbl[7] = '{8'd2,   8'd3,   8'd251, 4'd5, 8'd202};
    tbl[8] = '{8'd0,   8'd0,   8'd1,   4'd3, 8'd0};

    repeat (3) @(negedge clk);
    check("reset_outputs8", 64'({result8, done8, busy8, add_start8, add_sub8, add_a8, add_b8}), 64'd0);
    check("reset_outputsw", 64'(|{resultw, donew, busyw, add_startw, add_subw, add_aw, add_bw}), 64'd0);
    resetn8 = 1'b1;
    resetnw = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NTBL; k++)
      run8(tbl[k].a, tbl[k].b, tbl[k].m, int'(tbl[k].lat), tbl[k].exp);

    for (int k = 0; k < 30; k++) begin
      rm = 8'($urandom_range(255, 1)) | 8'd1;
      ra = 8'($urandom_range(255, 0)) % rm;
      rb = 8'($urandom_range(255, 0)) % rm;
      r  = redc_ref(wide_t'(ra), wide_t'(rb), wide_t'(rm), N8);
      run8(ra, rb, rm, int'($urandom_range(5, 1)), r[7:0]);
    end

    // A=0: no accumulate/parity adds, only the final subtract is issued.
    n_add8 = 0;
    n_sub8 = 0;
    run8(8'd0, 8'd12, 8'd13, 2, 8'd0);
    check("add_starts_a0", 64'(n_add8), 64'd1);
    check("add_subs_a0", 64'(n_sub8), 64'd1);

    // start re-pulsed while busy with different operands must be ignored.
    lat8 = 2;
    base = done_cnt8;
    start8_op(8'd5, 8'd7, 8'd13, 8'd1, 1'b1);
    repeat (6) @(negedge clk);
    check("busy_at_repulse8", 64'(busy8), 64'd1);
    start8_op(8'd1, 8'd1, 8'd13, 8'd0, 1'b0);
    wait_done8(base);
    repeat (30) @(negedge clk);
    check("result_held8", 64'(result8), 64'd1);

    // Asynchronous reset in the middle of a run, then a clean rerun.
    lat8 = 1;
    start8_op(8'd200, 8'd100, 8'd255, 8'd110, 1'b1);
    repeat (20) @(negedge clk);
    check("mid_op_busy8", 64'(busy8), 64'd1);
    resetn8 = 1'b0;
    #1;
    check("reset_mid_outputs8", 64'({result8, done8, busy8, add_start8, add_sub8, add_a8, add_b8}), 64'd0);
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    resetn8 = 1'b1;
    repeat (10) @(negedge clk);
    run8(8'd200, 8'd100, 8'd255, 3, 8'd110);

    // Full-width runs: random odd moduli with the top bit set, plus A=B=M-1.
    latw = 1;
    for (int k = 0; k < 4; k++) begin
      wm = rand_wide();
      wm[NW-1] = 1'b1;
      wm[0] = 1'b1;
      wa = rand_wide();
      wa = wa % wm;
      wb = rand_wide();
      wb = wb % wm;
      latw = (k % 2) + 1;
      runw(wa, wb, wm);
    end
    wm = rand_wide();
    wm[0] = 1'b1;
    runw(wm - 1'b1, wm - 1'b1, wm);

    check("cov_final_sub_taken", 64'(cov_take > 0), 64'd1);
    check("cov_final_sub_skipped", 64'(cov_skip > 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
